fnd_scan_controller: RTL and testbench

- Time-multiplexed driver for the 4-digit FND.
- Generates the 2-bit digit select and active-high blank enable consumed by the digit-select decoder, plus the active-low segment pattern for the selected digit.
- Adds a blanking gap between digits to prevent ghosting.
- New 16-bit display values commit only at frame boundaries, so no frame shows a torn value.

---
 rtl/fnd_pkg.sv | 54 +++++
 rtl/fnd_seg_decoder.sv | 18 +
 rtl/fnd_scan_controller.sv | 196 +++++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit FND scan controller: active-low segment
// glyphs ({dp,g,f,e,d,c,b,a}), scan state encoding and the digit count.
package fnd_pkg;

    localparam int FND_DIGITS = 4;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } fnd_state_e;

    // Glyph lookup; bit 7 (dp) is always 1 (off) here and is applied by the caller.
    function automatic logic [7:0] hex_glyph(input logic [3:0] hex);
        logic [7:0] g;
        case (hex)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational hex + decimal point to active-low 7-segment pattern.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_hex,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    logic [7:0] glyph;

    // Look up the glyph and overlay the active-low decimal point.
    always_comb begin
        glyph = hex_glyph(i_hex);
        o_seg = {~i_dp, glyph[6:0]};
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scanner with inter-digit blanking and
// frame-aligned commit of new display values.
// Optional build macro LEADING_ZERO_BLANK_EN: suppress leading zero digits
// (3, 2, 1) while they and every higher digit are zero; digit 0 always shows.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_BLANK | all digits off (o_En=1), counter 0..BLANK_CYCLES-1
// ST_SHOW  | selected digit lit (o_En=0), counter BLANK_CYCLES..SCAN_DIV-1
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic        i_load,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    output logic [1:0]  o_DigitSelect,
    output logic        o_En,
    output logic [7:0]  o_seg,
    output logic        o_frame_done
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [1:0]       LAST_DIGIT = 2'(FND_DIGITS - 1);

    fnd_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       digit_nxt;
    logic             en_nxt;
    logic             frame_done_nxt;
    logic [7:0]       seg_nxt;
    logic             seg_update;
    logic             commit;

    logic [15:0]      pend_value, pend_value_nxt;
    logic [3:0]       pend_dp, pend_dp_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic [15:0]      disp_value, disp_value_nxt;
    logic [3:0]       disp_dp, disp_dp_nxt;

    logic [3:0]       dec_hex;
    logic             dec_dp;
    logic [7:0]       dec_seg;
    logic [7:0]       seg_pat;

    // Slot timing and digit sequencing; a stop parks the scanner on digit 0 blank.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        digit_nxt      = o_DigitSelect;
        en_nxt         = o_En;
        frame_done_nxt = 1'b0;
        seg_update     = 1'b0;
        commit         = 1'b0;
        if (!i_run) begin
            state_nxt  = ST_BLANK;
            cnt_nxt    = '0;
            digit_nxt  = 2'd0;
            en_nxt     = 1'b1;
            seg_update = 1'b1;
            commit     = 1'b1;
        end else begin
            case (state)
                ST_BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        state_nxt = ST_SHOW;
                        en_nxt    = 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_nxt    = '0;
                        digit_nxt  = o_DigitSelect + 2'd1;
                        state_nxt  = ST_BLANK;
                        en_nxt     = 1'b1;
                        seg_update = 1'b1;
                        if (o_DigitSelect == LAST_DIGIT) begin
                            commit         = 1'b1;
                            frame_done_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b1;
                end
            endcase
        end
    end

    // Pending/display value handling; a load on a commit cycle bypasses pending.
    always_comb begin
        pend_value_nxt = pend_value;
        pend_dp_nxt    = pend_dp;
        pend_valid_nxt = pend_valid;
        disp_value_nxt = disp_value;
        disp_dp_nxt    = disp_dp;
        if (commit) begin
            pend_valid_nxt = 1'b0;
            if (i_load) begin
                disp_value_nxt = i_value;
                disp_dp_nxt    = i_dp;
            end else if (pend_valid) begin
                disp_value_nxt = pend_value;
                disp_dp_nxt    = pend_dp;
            end
        end else if (i_load) begin
            pend_value_nxt = i_value;
            pend_dp_nxt    = i_dp;
            pend_valid_nxt = 1'b1;
        end
    end

    // Pick the nibble of the upcoming digit from the value that will be on display.
    always_comb begin
        case (digit_nxt)
            2'd0:    dec_hex = disp_value_nxt[3:0];
            2'd1:    dec_hex = disp_value_nxt[7:4];
            2'd2:    dec_hex = disp_value_nxt[11:8];
            default: dec_hex = disp_value_nxt[15:12];
        endcase
        dec_dp = disp_dp_nxt[digit_nxt];
    end

    fnd_seg_decoder u_seg_decoder (
        .i_hex (dec_hex),
        .i_dp  (dec_dp),
        .o_seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_blank;

    // Blank a digit while it and all higher digits are zero; keep its dp.
    always_comb begin
        case (digit_nxt)
            2'd3:    lz_blank = (disp_value_nxt[15:12] == 4'h0);
            2'd2:    lz_blank = (disp_value_nxt[15:8]  == 8'h00);
            2'd1:    lz_blank = (disp_value_nxt[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
        seg_pat = lz_blank ? {~dec_dp, SEG_OFF[6:0]} : dec_seg;
    end
`else
    // Every digit shows its glyph.
    always_comb begin
        seg_pat = dec_seg;
    end
`endif

    // Segments only move when a new digit is selected (blank entry or stop).
    always_comb begin
        seg_nxt = seg_update ? seg_pat : o_seg;
    end

    // State, counter, value and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_BLANK;
            cnt           <= '0;
            o_DigitSelect <= 2'd0;
            o_En          <= 1'b1;
            o_seg         <= SEG_OFF;
            o_frame_done  <= 1'b0;
            pend_value    <= '0;
            pend_dp       <= '0;
            pend_valid    <= 1'b0;
            disp_value    <= '0;
            disp_dp       <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            o_DigitSelect <= digit_nxt;
            o_En          <= en_nxt;
            o_seg         <= seg_nxt;
            o_frame_done  <= frame_done_nxt;
            pend_value    <= pend_value_nxt;
            pend_dp       <= pend_dp_nxt;
            pend_valid    <= pend_valid_nxt;
            disp_value    <= disp_value_nxt;
            disp_dp       <= disp_dp_nxt;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with SCAN_DIV=8, BLANK_CYCLES=2.
// p counts clocks since scanning (re)started from reset: slot = p/8,
// digit = slot%4, o_En=1 while p%8 < 2, o_frame_done at every p%32==0 (p>0).
module tb_fnd_scan_controller;

    logic        clk;
    logic        i_reset;
    logic        i_run;
    logic        i_load;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [1:0]  o_DigitSelect;
    logic        o_En;
    logic [7:0]  o_seg;
    logic        o_frame_done;

    int n_checks;
    int n_pass;
    int p;

    fnd_scan_controller #(
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2),
        .CNT_W        (3)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_run         (i_run),
        .i_load        (i_load),
        .i_value       (i_value),
        .i_dp          (i_dp),
        .o_DigitSelect (o_DigitSelect),
        .o_En          (o_En),
        .o_seg         (o_seg),
        .o_frame_done  (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        p = p + 1;
    endtask

    task automatic run_to(input int target);
        while (p < target) step();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_run   = 1'b1;
        i_load  = 1'b0;
        i_value = 16'h0;
        i_dp    = 4'h0;
        step(); step(); step();
        n_checks++;
        if (o_En !== 1'b1) $display("FAIL reset_en got=%b exp=1", o_En); else n_pass++;
        n_checks++;
        if (o_DigitSelect !== 2'd0) $display("FAIL reset_digit got=%0d exp=0", o_DigitSelect); else n_pass++;
        n_checks++;
        if (o_seg !== 8'hFF) $display("FAIL reset_seg got=%h exp=ff", o_seg); else n_pass++;
        n_checks++;
        if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); else n_pass++;
        i_reset = 1'b0;
        p = 0;
    endtask

    task automatic test_scan();
        logic       exp_en;
        logic [1:0] exp_dig;
        logic       exp_fd;
        logic [7:0] exp_seg;
        for (int k = 0; k < 64; k++) begin
            exp_en  = ((p % 8) < 2);
            exp_dig = 2'((p / 8) % 4);
            exp_fd  = ((p % 32) == 0) && (p > 0);
            exp_seg = (p < 8) ? 8'hFF : 8'hC0;
            n_checks++;
            if (o_En !== exp_en) $display("FAIL scan_en p=%0d got=%b exp=%b", p, o_En, exp_en); else n_pass++;
            n_checks++;
            if (o_DigitSelect !== exp_dig) $display("FAIL scan_digit p=%0d got=%0d exp=%0d", p, o_DigitSelect, exp_dig); else n_pass++;
            n_checks++;
            if (o_frame_done !== exp_fd) $display("FAIL scan_frame_done p=%0d got=%b exp=%b", p, o_frame_done, exp_fd); else n_pass++;
            n_checks++;
            if (o_seg !== exp_seg) $display("FAIL scan_seg p=%0d got=%h exp=%h", p, o_seg, exp_seg); else n_pass++;
            step();
        end
    endtask

    task automatic test_load();
        run_to(70);
        i_load = 1'b1; i_value = 16'h1234; i_dp = 4'b0001;
        step();
        i_load = 1'b0;
        run_to(88);
        n_checks++;
        if (o_seg !== 8'hC0) $display("FAIL load_old_persists got=%h exp=c0", o_seg); else n_pass++;
        run_to(96);
        n_checks++;
        if (o_frame_done !== 1'b1 || o_DigitSelect !== 2'd0)
            $display("FAIL load_wrap got fd=%b dig=%0d exp fd=1 dig=0", o_frame_done, o_DigitSelect);
        else n_pass++;
        n_checks++;
        if (o_seg !== 8'h19) $display("FAIL load_digit0 got=%h exp=19", o_seg); else n_pass++;
        run_to(104);
        n_checks++;
        if (o_seg !== 8'hB0) $display("FAIL load_digit1 got=%h exp=b0", o_seg); else n_pass++;
        run_to(112);
        n_checks++;
        if (o_seg !== 8'hA4) $display("FAIL load_digit2 got=%h exp=a4", o_seg); else n_pass++;
        run_to(120);
        n_checks++;
        if (o_seg !== 8'hF9 || o_DigitSelect !== 2'd3)
            $display("FAIL load_digit3 got seg=%h dig=%0d exp seg=f9 dig=3", o_seg, o_DigitSelect);
        else n_pass++;
    endtask

    task automatic test_last_wins();
        run_to(130);
        i_load = 1'b1; i_value = 16'hAAAA; i_dp = 4'b0000;
        step();
        i_load = 1'b0;
        run_to(136);
        n_checks++;
        if (o_seg !== 8'hB0) $display("FAIL lastwins_d1_old got=%h exp=b0", o_seg); else n_pass++;
        run_to(140);
        i_load = 1'b1; i_value = 16'h5555;
        step();
        i_load = 1'b0;
        run_to(152);
        n_checks++;
        if (o_seg !== 8'hF9) $display("FAIL lastwins_d3_old got=%h exp=f9", o_seg); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            run_to(160 + 8 * d);
            n_checks++;
            if (o_seg !== 8'h92 || o_DigitSelect !== 2'(d))
                $display("FAIL lastwins_digit%0d got seg=%h dig=%0d exp seg=92", d, o_seg, o_DigitSelect);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        run_to(191);
        i_load = 1'b1; i_value = 16'hBEEF; i_dp = 4'b0000;
        step();
        i_load = 1'b0;
        n_checks++;
        if (o_frame_done !== 1'b1 || o_DigitSelect !== 2'd0)
            $display("FAIL bypass_wrap got fd=%b dig=%0d exp fd=1 dig=0", o_frame_done, o_DigitSelect);
        else n_pass++;
        n_checks++;
        if (o_seg !== 8'h8E) $display("FAIL bypass_digit0 got=%h exp=8e", o_seg); else n_pass++;
        run_to(200);
        n_checks++;
        if (o_seg !== 8'h86) $display("FAIL bypass_digit1 got=%h exp=86", o_seg); else n_pass++;
        run_to(208);
        n_checks++;
        if (o_seg !== 8'h86) $display("FAIL bypass_digit2 got=%h exp=86", o_seg); else n_pass++;
        run_to(216);
        n_checks++;
        if (o_seg !== 8'h83) $display("FAIL bypass_digit3 got=%h exp=83", o_seg); else n_pass++;
        run_to(224);
        n_checks++;
        if (o_seg !== 8'h8E || o_frame_done !== 1'b1)
            $display("FAIL bypass_next_frame got seg=%h fd=%b exp seg=8e fd=1", o_seg, o_frame_done);
        else n_pass++;
    endtask

    task automatic test_stop();
        run_to(244);
        n_checks++;
        if (o_En !== 1'b0 || o_DigitSelect !== 2'd2)
            $display("FAIL stop_pre got en=%b dig=%0d exp en=0 dig=2", o_En, o_DigitSelect);
        else n_pass++;
        i_run = 1'b0;
        step();
        n_checks++;
        if (o_En !== 1'b1 || o_DigitSelect !== 2'd0 || o_seg !== 8'h8E)
            $display("FAIL stop_next got en=%b dig=%0d seg=%h exp en=1 dig=0 seg=8e", o_En, o_DigitSelect, o_seg);
        else n_pass++;
        step(); step();
        n_checks++;
        if (o_En !== 1'b1 || o_frame_done !== 1'b0)
            $display("FAIL stop_hold got en=%b fd=%b exp en=1 fd=0", o_En, o_frame_done);
        else n_pass++;
        i_load = 1'b1; i_value = 16'h0007; i_dp = 4'b0001;
        step();
        i_load = 1'b0;
        n_checks++;
        if (o_seg !== 8'h78) $display("FAIL stop_load_commit got=%h exp=78", o_seg); else n_pass++;
        i_run = 1'b1;
        step();
        n_checks++;
        if (o_En !== 1'b1 || o_DigitSelect !== 2'd0)
            $display("FAIL restart_blank1 got en=%b dig=%0d exp en=1 dig=0", o_En, o_DigitSelect);
        else n_pass++;
        step();
        n_checks++;
        if (o_En !== 1'b0 || o_DigitSelect !== 2'd0 || o_seg !== 8'h78)
            $display("FAIL restart_show got en=%b dig=%0d seg=%h exp en=0 dig=0 seg=78", o_En, o_DigitSelect, o_seg);
        else n_pass++;
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (o_En !== 1'b1 || o_DigitSelect !== 2'd1 || o_seg !== 8'hC0)
            $display("FAIL restart_digit1 got en=%b dig=%0d seg=%h exp en=1 dig=1 seg=c0", o_En, o_DigitSelect, o_seg);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(); step(); step();
        i_load = 1'b1; i_value = 16'h9999; i_dp = 4'b1111;
        step();
        i_load = 1'b0;
        step();
        i_reset = 1'b1;
        step();
        n_checks++;
        if (o_En !== 1'b1 || o_DigitSelect !== 2'd0 || o_seg !== 8'hFF || o_frame_done !== 1'b0)
            $display("FAIL midreset_outputs got en=%b dig=%0d seg=%h fd=%b exp en=1 dig=0 seg=ff fd=0",
                     o_En, o_DigitSelect, o_seg, o_frame_done);
        else n_pass++;
        i_load = 1'b1; i_value = 16'h8888; i_dp = 4'b1111;
        step();
        i_load  = 1'b0;
        i_reset = 1'b0;
        p = 0;
        run_to(2);
        n_checks++;
        if (o_En !== 1'b0 || o_seg !== 8'hFF)
            $display("FAIL midreset_first_show got en=%b seg=%h exp en=0 seg=ff", o_En, o_seg);
        else n_pass++;
        run_to(8);
        n_checks++;
        if (o_seg !== 8'hC0 || o_DigitSelect !== 2'd1)
            $display("FAIL midreset_digit1 got seg=%h dig=%0d exp seg=c0 dig=1", o_seg, o_DigitSelect);
        else n_pass++;
        run_to(32);
        n_checks++;
        if (o_seg !== 8'hC0 || o_frame_done !== 1'b1)
            $display("FAIL midreset_no_pending got seg=%h fd=%b exp seg=c0 fd=1", o_seg, o_frame_done);
        else n_pass++;
    endtask

    task automatic test_leading_zero();
        logic [7:0] exp_hi;
`ifdef LEADING_ZERO_BLANK_EN
        exp_hi = 8'hFF;
`else
        exp_hi = 8'hC0;
`endif
        run_to(40);
        i_load = 1'b1; i_value = 16'h0040; i_dp = 4'b0000;
        step();
        i_load = 1'b0;
        run_to(64);
        n_checks++;
        if (o_seg !== 8'hC0) $display("FAIL lz_digit0 got=%h exp=c0", o_seg); else n_pass++;
        run_to(72);
        n_checks++;
        if (o_seg !== 8'h99) $display("FAIL lz_digit1 got=%h exp=99", o_seg); else n_pass++;
        run_to(80);
        n_checks++;
        if (o_seg !== exp_hi) $display("FAIL lz_digit2 got=%h exp=%h", o_seg, exp_hi); else n_pass++;
        run_to(88);
        n_checks++;
        if (o_seg !== exp_hi || o_En !== 1'b1)
            $display("FAIL lz_digit3 got seg=%h en=%b exp seg=%h en=1", o_seg, o_En, exp_hi);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        p        = 0;
        i_reset  = 1'b1;
        i_run    = 1'b0;
        i_load   = 1'b0;
        i_value  = 16'h0;
        i_dp     = 4'h0;
        test_reset();
        test_scan();
        test_load();
        test_last_wins();
        test_back_to_back();
        test_stop();
        test_reset_mid();
        test_leading_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
